// File: rtl/ex_pkg.sv
// rtl/ex_pkg.sv - shared types and inline FP constant tables for the operand collector
// Contents: collector FSM state enum, 64-bit operand type, FP32/FP64 inline
// constant tables for encodings 240..248, and a lookup helper.
package ex_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DONE
    } collector_state_t;

    typedef logic [63:0] operand64_t;

    // Entry k corresponds to encoding 240+k:
    // 0.5, -0.5, 1.0, -1.0, 2.0, -2.0, 4.0, -4.0, 1/(2*pi)
    localparam logic [8:0][63:0] FP64_CONST = {
        64'h3FC4_5F30_6DC9_C882,
        64'hC010_0000_0000_0000,
        64'h4010_0000_0000_0000,
        64'hC000_0000_0000_0000,
        64'h4000_0000_0000_0000,
        64'hBFF0_0000_0000_0000,
        64'h3FF0_0000_0000_0000,
        64'hBFE0_0000_0000_0000,
        64'h3FE0_0000_0000_0000
    };

    localparam logic [8:0][31:0] FP32_CONST = {
        32'h3E22_F983,
        32'hC080_0000,
        32'h4080_0000,
        32'hC000_0000,
        32'h4000_0000,
        32'hBF80_0000,
        32'h3F80_0000,
        32'hBF00_0000,
        32'h3F00_0000
    };

    // sel must be 0..8; 32-bit results are zero-extended.
    function automatic operand64_t fp_inline_const(input logic [3:0] sel, input logic is64);
        operand64_t v;
        v = is64 ? FP64_CONST[sel] : {32'd0, FP32_CONST[sel]};
        return v;
    endfunction

endpackage

// File: rtl/src_const_decode.sv
// rtl/src_const_decode.sv - combinational decode of one source encoding
// Ports:
//   src      [8:0]  source encoding, bit 8 selects VGPR
//   is64            64-bit operand select
//   literal  [31:0] literal constant for encoding 255
//   vccz/scc/execz  status bits for encodings 251/253/252
//   value    [63:0] resolved constant (0 for register or illegal sources)
//   illegal         reserved encoding or bad register range
//   is_reg          source needs register reads
module src_const_decode
    import ex_pkg::*;
#(
    parameter int SGPR_DEPTH = 106
) (
    input  logic [8:0]  src,
    input  logic        is64,
    input  logic [31:0] literal,
    input  logic        vccz,
    input  logic        scc,
    input  logic        execz,
    output operand64_t  value,
    output logic        illegal,
    output logic        is_reg
);

    logic [7:0] enc;
    operand64_t neg_val;

    assign enc     = src[7:0];
    // Negative inline integers 193..208 -> -1..-16, full 64-bit two's complement.
    assign neg_val = 64'd0 - {56'd0, enc - 8'd192};

    always_comb begin
        value   = '0;
        illegal = 1'b0;
        is_reg  = 1'b0;
        if (src[8]) begin
            // VGPR 255 has no partner register for the high word.
            if (is64 && enc == 8'hFF) illegal = 1'b1;
            else                      is_reg  = 1'b1;
        end else if (enc == 8'd125 || enc == 8'd128) begin
            value = '0;
        end else if (enc < 8'd128) begin
            if (int'(enc) >= SGPR_DEPTH ||
                (is64 && (enc[0] || int'(enc) + 1 >= SGPR_DEPTH)))
                illegal = 1'b1;
            else
                is_reg = 1'b1;
        end else if (enc <= 8'd192) begin
            value = {56'd0, enc - 8'd128};
        end else if (enc <= 8'd208) begin
            value = is64 ? neg_val : {32'd0, neg_val[31:0]};
        end else if (enc >= 8'd240 && enc <= 8'd248) begin
            value = fp_inline_const(4'(enc - 8'd240), is64);
        end else begin
            case (enc)
                8'd251:  value = {63'd0, vccz};
                8'd252:  value = {63'd0, execz};
                8'd253:  value = {63'd0, scc};
                8'd255:  value = {32'd0, literal};
                default: illegal = 1'b1;
            endcase
        end
    end

endmodule

// File: rtl/src_operand_collector.sv
// rtl/src_operand_collector.sv - gathers NUM_SRC source operands from constants and SGPR/VGPR reads
// Ports:
//   clk, rst                  clock, async active-high reset
//   in_valid/in_ready         instruction handshake
//   in_src/in_is64/in_literal per-source encodings, width selects, literal
//   in_vccz/in_scc/in_execz   status bits for status-constant encodings
//   sgpr_rd_*/vgpr_rd_*       register read ports, data one cycle after enable
//   out_valid/out_ready       result handshake
//   out_operand/out_illegal   resolved operands and per-source illegal flags
module src_operand_collector
    import ex_pkg::*;
#(
    parameter int NUM_SRC    = 3,
    parameter int SGPR_DEPTH = 106
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [NUM_SRC-1:0][8:0]   in_src,
    input  logic [NUM_SRC-1:0]        in_is64,
    input  logic [31:0]               in_literal,
    input  logic                      in_vccz,
    input  logic                      in_scc,
    input  logic                      in_execz,
    output logic                      sgpr_rd_en,
    output logic [7:0]                sgpr_rd_addr,
    input  logic [31:0]               sgpr_rd_data,
    output logic                      vgpr_rd_en,
    output logic [7:0]                vgpr_rd_addr,
    input  logic [31:0]               vgpr_rd_data,
    output logic                      out_valid,
    input  logic                      out_ready,
    output operand64_t [NUM_SRC-1:0]  out_operand,
    output logic [NUM_SRC-1:0]        out_illegal
);

    localparam int MAX_RD = 2 * NUM_SRC;
    localparam int IDX_W  = $clog2(MAX_RD + 1);
    localparam int LST_N  = 1 << IDX_W;
    localparam int SRC_W  = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    // One scheduled register read: which source/half it fills and where from.
    typedef struct packed {
        logic [SRC_W-1:0] src;
        logic             half;
        logic             vgpr;
        logic [7:0]       addr;
    } rd_slot_t;

    collector_state_t          state_q, state_d;
    operand64_t [NUM_SRC-1:0]  dec_value;
    logic [NUM_SRC-1:0]        dec_illegal;
    logic [NUM_SRC-1:0]        dec_is_reg;
    rd_slot_t                  lst_d [LST_N];
    rd_slot_t                  lst_q [LST_N];
    logic [IDX_W-1:0]          r_d, r_total_q, rd_idx_q;
    operand64_t [NUM_SRC-1:0]  operand_q;
    logic [NUM_SRC-1:0]        illegal_q;
    logic                      pend_valid_q;
    rd_slot_t                  pend_q;
    rd_slot_t                  cur;
    logic                      accept;
    logic                      issue;
    logic [31:0]               rd_data_sel;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_dec
        src_const_decode #(
            .SGPR_DEPTH (SGPR_DEPTH)
        ) u_dec (
            .src     (in_src[g]),
            .is64    (in_is64[g]),
            .literal (in_literal),
            .vccz    (in_vccz),
            .scc     (in_scc),
            .execz   (in_execz),
            .value   (dec_value[g]),
            .illegal (dec_illegal[g]),
            .is_reg  (dec_is_reg[g])
        );
    end

    // Flatten register sources into an ordered read schedule:
    // src0 low, src0 high, src1 low, ...
    always_comb begin
        r_d = '0;
        for (int k = 0; k < LST_N; k++) lst_d[k] = '0;
        for (int s = 0; s < NUM_SRC; s++) begin
            if (dec_is_reg[s]) begin
                lst_d[r_d] = '{src: SRC_W'(s), half: 1'b0, vgpr: in_src[s][8],
                               addr: in_src[s][7:0]};
                r_d = r_d + IDX_W'(1);
                if (in_is64[s]) begin
                    lst_d[r_d] = '{src: SRC_W'(s), half: 1'b1, vgpr: in_src[s][8],
                                   addr: in_src[s][7:0] + 8'd1};
                    r_d = r_d + IDX_W'(1);
                end
            end
        end
    end

    assign accept      = (state_q == ST_IDLE) && in_valid;
    assign issue       = (state_q == ST_FETCH) && (rd_idx_q != r_total_q);
    assign cur         = lst_q[rd_idx_q];
    assign rd_data_sel = pend_q.vgpr ? vgpr_rd_data : sgpr_rd_data;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_valid) state_d = (r_d == '0) ? ST_DONE : ST_FETCH;
            // One extra FETCH cycle after the last issue lets its data land.
            ST_FETCH: if (rd_idx_q == r_total_q) state_d = ST_DONE;
            ST_DONE:  if (out_ready) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready     = (state_q == ST_IDLE);
        out_valid    = (state_q == ST_DONE);
        sgpr_rd_en   = issue && !cur.vgpr;
        vgpr_rd_en   = issue && cur.vgpr;
        sgpr_rd_addr = sgpr_rd_en ? cur.addr : 8'd0;
        vgpr_rd_addr = vgpr_rd_en ? cur.addr : 8'd0;
        out_operand  = operand_q;
        out_illegal  = illegal_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            r_total_q    <= '0;
            rd_idx_q     <= '0;
            operand_q    <= '0;
            illegal_q    <= '0;
            pend_valid_q <= 1'b0;
            pend_q       <= '0;
            for (int k = 0; k < LST_N; k++) lst_q[k] <= '0;
        end else begin
            state_q      <= state_d;
            pend_valid_q <= issue;
            pend_q       <= cur;
            if (accept) begin
                for (int k = 0; k < LST_N; k++) lst_q[k] <= lst_d[k];
                r_total_q <= r_d;
                rd_idx_q  <= '0;
                operand_q <= dec_value;
                illegal_q <= dec_illegal;
            end else begin
                if (issue) rd_idx_q <= rd_idx_q + IDX_W'(1);
                if (pend_valid_q) begin
                    if (pend_q.half) operand_q[pend_q.src][63:32] <= rd_data_sel;
                    else             operand_q[pend_q.src][31:0]  <= rd_data_sel;
                end
            end
        end
    end

endmodule

// File: doc/src_operand_collector.md
SRC_OPERAND_COLLECTOR -- requirements
Module: src_operand_collector

Interface
REQ-001 SHALL have parameter NUM_SRC, default 3, number of source operands per instruction (1..3).
REQ-002 SHALL have parameter SGPR_DEPTH, default 106, number of addressable SGPRs.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port in_valid/in_ready  input/output  1/1  instruction handshake.
REQ-006 SHALL have port in_src  input  NUM_SRC x 9  source encodings; bit 8 = VGPR, bits 7:0 = scalar encoding.
REQ-007 SHALL have port in_is64  input  NUM_SRC  per-source 64-bit operand select.
REQ-008 SHALL have port in_literal  input  32  literal constant (encoding 255).
REQ-009 SHALL have port in_vccz, in_scc, in_execz  input  1 each  status bits.
REQ-010 SHALL have port sgpr_rd_en/sgpr_rd_addr/sgpr_rd_data  output/output/input  1/8/32  SGPR read port, data valid one cycle after enable.
REQ-011 SHALL have port vgpr_rd_en/vgpr_rd_addr/vgpr_rd_data  output/output/input  1/8/32  VGPR read port, same timing.
REQ-012 SHALL have port out_valid/out_ready  output/input  1/1  result handshake.
REQ-013 SHALL have port out_operand  output  NUM_SRC x 64  resolved operands.
REQ-014 SHALL have port out_illegal  output  NUM_SRC  per-source illegal/reserved flag.

Function
REQ-015 SHALL implement FSM IDLE -> FETCH -> DONE -> IDLE; in_ready = (state == IDLE).
REQ-016 On accept (end of cycle T), SHALL capture all inputs; R = count of register reads (1 per 32-bit source, 2 per 64-bit source).
REQ-017 R = 0: SHALL go directly to DONE, out_valid high in cycle T+1.
REQ-018 R > 0: SHALL issue exactly one read per cycle in cycles T+1..T+R, order src0 low, src0 high, src1 low, ...; out_valid high in cycle T+R+2.
REQ-019 64-bit register source SHALL read addr then addr+1; low word from addr.
REQ-020 Constants SHALL decode: 128/125 -> 0; 129..192 -> value-128; 193..208 -> -(value-192); 240..248 -> FP32 constants (FP64 encodings when is64); 251/252/253 -> zero-extended vccz/execz/scc; 255 -> zero-extended literal.
REQ-021 64-bit inline integers SHALL be sign-extended to 64 bits; 32-bit results SHALL zero upper 32 bits.
REQ-022 Reserved encodings (209..239, 249, 250, 254), odd SGPR base with is64, SGPR base+1 >= SGPR_DEPTH, VGPR 255 with is64 SHALL set out_illegal, operand = 0, and issue no read.
REQ-023 DONE SHALL hold out_operand/out_illegal stable until out_valid && out_ready; return to IDLE next cycle.
REQ-024 sgpr_rd_en and vgpr_rd_en SHALL never both be high; rd_addr SHALL be 0 when its enable is low.
REQ-025 in_valid while not in IDLE SHALL be ignored (no capture).

Reset
REQ-026 rst SHALL asynchronously force IDLE, out_valid=0, out_operand=0, out_illegal=0, rd_en=0, rd_addr=0, in_ready=1 after release.
REQ-027 rst mid-FETCH/DONE SHALL abort the instruction; no partial result emitted after release.

Structure
REQ-028 FSM state enum, FP64 constant values, and 64-bit operand typedef SHALL live in ex_pkg.
REQ-029 Per-source constant decode SHALL be sub-module src_const_decode (combinational, is64-aware), instantiated NUM_SRC times.

Verification
REQ-030 src={129,193,242}, is64=0 -> out_valid at T+1, operands 0x1, 0xFFFFFFFF, 0x3F800000, no reads.
REQ-031 src0=SGPR 4 is64=1, src1=VGPR 7 (0x107), src2=255 literal 0xDEADBEEF -> reads S4,S5,V7 in T+1..T+3, out_valid T+5, operand0={S5,S4}, operand2=0x00000000DEADBEEF.
REQ-032 src0=193 is64=1, src1=242 is64=1 -> 0xFFFFFFFFFFFFFFFF, 0x3FF0000000000000.
REQ-033 src0=SGPR 5 is64=1, src1=250 -> out_illegal=3'b011, operands 0, no reads.
REQ-034 Hold out_ready=0 for 4 cycles in DONE -> outputs stable, in_ready=0; then handshake -> IDLE.
REQ-035 Assert rst in cycle T+2 of an R=3 fetch -> all outputs 0 immediately, no out_valid after release, next instruction decodes correctly.
